// File: rtl/sprite_palette_ctrl.sv
// rtl/sprite_palette_ctrl.sv - banked sprite palette lookup with frame-paced fade
//
// Purpose: NUM_BANKS register-file palettes of 2^IDX_W {R,G,B} entries.
// Lookups run through a two-register pipeline. A global fade level scales
// every output channel. The fade level steps once every FADE_DIV frame ticks
// toward 0 (fade-out) or full scale (fade-in).
//
// Ports:
//   Clk, Reset_n              clock, synchronous active-low reset
//   wr_en/wr_bank/wr_addr/wr_data   palette entry write, data is {R,G,B}
//   in_valid/index/bank       lookup request
//   frame_tick                one pulse per frame, paces the fade
//   fade_start/fade_dir       fade command, dir 0=out, 1=in
//   out_valid/red/green/blue/transparent   lookup result, two cycles later
//   fade_busy/fade_done       fade in progress / one-cycle completion pulse
module sprite_palette_ctrl #(
  parameter int IDX_W      = 4,
  parameter int CH_W       = 4,
  parameter int NUM_BANKS  = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FADE_DIV   = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic [BANK_W-1:0] bank,
  input  logic              frame_tick,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              fade_busy,
  output logic              fade_done
);

  localparam int DEPTH   = 1 << IDX_W;
  localparam int ENTRIES = NUM_BANKS * DEPTH;
  localparam int ADDR_W  = BANK_W + IDX_W;
  localparam int CNT_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [CH_W:0]       L_FULL    = {1'b1, {CH_W{1'b0}}};
  localparam logic [BANK_W-1:0]   BANK_MASK = BANK_W'(NUM_BANKS - 1);
  localparam logic [IDX_W-1:0]    TRANSP    = IDX_W'(TRANSP_IDX);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(FADE_DIV - 1);

  typedef enum logic {S_IDLE, S_FADING} state_t;

  // Palette storage, flattened as {bank, index}. Bank is masked so a
  // single-bank build always addresses bank 0.
  logic [3*CH_W-1:0] mem [ENTRIES];
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr_full;

  assign rd_addr      = {bank & BANK_MASK, index};
  assign wr_addr_full = {wr_bank & BANK_MASK, wr_addr};

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr_full] <= wr_data;
    end
  end

  // Stage 1: reading mem here sees the pre-write value, giving
  // read-before-write on a same-cycle collision.
  logic              s1_valid;
  logic [3*CH_W-1:0] s1_entry;
  logic              s1_transp;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_entry  <= '0;
      s1_transp <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_entry  <= mem[rd_addr];
      s1_transp <= (index == TRANSP);
    end
  end

  // (c * L) >> CH_W; with L <= 2^CH_W the result always fits in CH_W bits.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [CH_W:0]   l);
    logic [2*CH_W:0] p;
    p = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, l};
    return CH_W'(p >> CH_W);
  endfunction

  logic [CH_W:0] level;

  // Stage 2: the fade level is taken as it stands at this edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      out_valid   <= s1_valid;
      red         <= s1_valid ? scale(s1_entry[3*CH_W-1:2*CH_W], level) : '0;
      green       <= s1_valid ? scale(s1_entry[2*CH_W-1:CH_W], level)   : '0;
      blue        <= s1_valid ? scale(s1_entry[CH_W-1:0], level)        : '0;
      transparent <= s1_valid & s1_transp;
    end
  end

  // Fade FSM
  state_t            state, state_n;
  logic [CH_W:0]     level_n;
  logic [CNT_W-1:0]  step_cnt, step_cnt_n;
  logic              dir, dir_n;
  logic              done_n;
  logic [CH_W:0]     start_target;
  logic [CH_W:0]     cur_target;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      level     <= L_FULL;
      step_cnt  <= '0;
      dir       <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      step_cnt  <= step_cnt_n;
      dir       <= dir_n;
      fade_done <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    level_n      = level;
    step_cnt_n   = step_cnt;
    dir_n        = dir;
    done_n       = 1'b0;
    start_target = fade_dir ? L_FULL : '0;
    cur_target   = dir ? L_FULL : '0;

    // A command takes priority over a coincident tick, which is dropped.
    if (fade_start) begin
      dir_n      = fade_dir;
      step_cnt_n = '0;
      if (level == start_target) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = S_FADING;
      end
    end else if (state == S_FADING && frame_tick) begin
      if (step_cnt == CNT_LAST) begin
        step_cnt_n = '0;
        level_n    = dir ? level + (CH_W+1)'(1) : level - (CH_W+1)'(1);
        if (level_n == cur_target) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end else begin
        step_cnt_n = step_cnt + CNT_W'(1);
      end
    end
  end

  assign fade_busy = (state == S_FADING);

endmodule

// File: tb/tb_sprite_palette_ctrl.sv
// tb/tb_sprite_palette_ctrl.sv - self-checking bench for sprite_palette_ctrl
module tb_sprite_palette_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        in_valid;
  logic [3:0]  index;
  logic [1:0]  bank;
  logic        frame_tick;
  logic        fade_start;
  logic        fade_dir;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        fade_busy;
  logic        fade_done;

  sprite_palette_ctrl #(
    .IDX_W(4), .CH_W(4), .NUM_BANKS(4), .TRANSP_IDX(0), .FADE_DIV(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .index(index), .bank(bank),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .transparent(transparent), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] rgb;
    logic        t;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  bank;
    logic [3:0]  idx;
    logic [11:0] data;
    logic [11:0] exp_rgb;
    logic        exp_t;
  } vec_t;

  exp_t        sb[$];
  logic [11:0] m_mem [4][16];
  int          m_lvl;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          run = 0;
  int          max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] fexp(input logic [11:0] c, input int l);
    int r, g, b;
    r = (int'(c[11:8]) * l) >> 4;
    g = (int'(c[7:4]) * l) >> 4;
    b = (int'(c[3:0]) * l) >> 4;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  // Output monitor: scoreboard pop on every valid output, zero check otherwise.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    cyc++;
    if (fade_done) done_cnt++;
    if (out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
        chk("transparent", 32'(transparent), 32'(e.t));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      run = 0;
      chk("idle_outputs_zero", {19'd0, red, green, blue, transparent}, 32'd0);
    end
  end

  task automatic do_write(input int b, input int a, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = 2'(b); wr_addr = 4'(a); wr_data = d;
    m_mem[b][a] = d;
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic do_lookup_exp(input int b, input int i, input logic [11:0] rgb, input logic t);
    exp_t e;
    in_valid = 1'b1; bank = 2'(b); index = 4'(i);
    e.rgb = rgb; e.t = t; e.due = cyc + 2;
    sb.push_back(e);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic do_lookup(input int b, input int i);
    do_lookup_exp(b, i, fexp(m_mem[b][i], m_lvl), i == 0);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_fade(input logic d);
    fade_start = 1'b1; fade_dir = d;
    @(negedge Clk);
    fade_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   d0;
    exp_t e;

    vecs[0] = '{2'd1, 4'd5,  12'hE93, 12'hE93, 1'b0};
    vecs[1] = '{2'd0, 4'd0,  12'hABC, 12'hABC, 1'b1};
    vecs[2] = '{2'd2, 4'd0,  12'h123, 12'h123, 1'b1};
    vecs[3] = '{2'd3, 4'd15, 12'hFFF, 12'hFFF, 1'b0};
    vecs[4] = '{2'd0, 4'd7,  12'h5A0, 12'h5A0, 1'b0};
    vecs[5] = '{2'd2, 4'd9,  12'h0F1, 12'h0F1, 1'b0};

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) m_mem[b][a] = 12'h000;
    m_lvl = 16;

    Reset_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; index = '0; bank = '0;
    frame_tick = 1'b0; fade_start = 1'b0; fade_dir = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fade_busy", 32'(fade_busy), 32'd0);
    chk("reset_fade_done", 32'(fade_done), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Table: write all, then look up back-to-back.
    for (int i = 0; i < 6; i++) do_write(vecs[i].bank, vecs[i].idx, vecs[i].data);
    for (int i = 0; i < 6; i++)
      do_lookup_exp(vecs[i].bank, vecs[i].idx, vecs[i].exp_rgb, vecs[i].exp_t);
    drain();

    // Exact two-cycle latency on bank1 idx5.
    in_valid = 1'b1; bank = 2'd1; index = 4'd5;
    e.rgb = 12'hE93; e.t = 1'b0; e.due = cyc + 2;
    sb.push_back(e);
    @(negedge Clk);
    in_valid = 1'b0;
    chk("lat_after_1_edge", 32'(out_valid), 32'd0);
    @(negedge Clk);
    chk("lat_after_2_edges", 32'(out_valid), 32'd1);
    drain();

    // 16 back-to-back lookups over a fully loaded bank 0.
    for (int i = 0; i < 16; i++) do_write(0, i, {4'(i), 4'(15 - i), 4'(i ^ 5)});
    max_run = 0;
    for (int i = 0; i < 16; i++) do_lookup(0, i);
    drain();
    chk("back_to_back_run", 32'(max_run), 32'd16);

    // Read-before-write on a same-cycle collision.
    do_write(0, 3, 12'hFFF);
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 4'd3; wr_data = 12'h111;
    in_valid = 1'b1; bank = 2'd0; index = 4'd3;
    e.rgb = 12'hFFF; e.t = 1'b0; e.due = cyc + 2;
    sb.push_back(e);
    m_mem[0][3] = 12'h111;
    @(negedge Clk);
    wr_en = 1'b0; in_valid = 1'b0;
    do_lookup(0, 3);
    drain();

    // Fade-out over 32 ticks with a midway check at L=8.
    d0 = done_cnt;
    do_fade(1'b0);
    chk("fade_out_busy", 32'(fade_busy), 32'd1);
    repeat (16) do_tick();
    chk("fade_out_mid_busy", 32'(fade_busy), 32'd1);
    m_lvl = 8;
    do_lookup_exp(1, 5, 12'h741, 1'b0);
    drain();
    repeat (16) do_tick();
    chk("fade_out_end_busy", 32'(fade_busy), 32'd0);
    chk("fade_out_done_pulses", 32'(done_cnt - d0), 32'd1);
    m_lvl = 0;
    do_lookup_exp(1, 5, 12'h000, 1'b0);
    do_lookup(0, 0);
    drain();

    // Fade-in back to full scale.
    d0 = done_cnt;
    do_fade(1'b1);
    repeat (32) do_tick();
    chk("fade_in_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("fade_in_end_busy", 32'(fade_busy), 32'd0);
    m_lvl = 16;

    // Fade-in at full scale: done next cycle, never busy.
    d0 = done_cnt;
    fade_start = 1'b1; fade_dir = 1'b1;
    @(negedge Clk);
    fade_start = 1'b0;
    chk("noop_busy_1", 32'(fade_busy), 32'd0);
    chk("noop_done_high", 32'(fade_done), 32'd1);
    @(negedge Clk);
    chk("noop_busy_2", 32'(fade_busy), 32'd0);
    chk("noop_done_low", 32'(fade_done), 32'd0);
    chk("noop_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Fade-out to L=5, then restart as fade-in with a coincident tick.
    d0 = done_cnt;
    do_fade(1'b0);
    repeat (22) do_tick();
    m_lvl = 5;
    do_lookup_exp(1, 5, 12'h420, 1'b0);
    drain();
    fade_start = 1'b1; fade_dir = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    fade_start = 1'b0; frame_tick = 1'b0;
    chk("restart_busy", 32'(fade_busy), 32'd1);
    do_tick();
    do_lookup_exp(1, 5, 12'h420, 1'b0);
    drain();
    repeat (21) do_tick();
    chk("restart_end_busy", 32'(fade_busy), 32'd0);
    chk("restart_done_pulses", 32'(done_cnt - d0), 32'd1);
    m_lvl = 16;
    do_lookup(1, 5);
    drain();

    // Reset during a fade with lookups in flight.
    d0 = done_cnt;
    do_fade(1'b0);
    repeat (4) do_tick();
    m_lvl = 14;
    do_lookup_exp(1, 5, 12'hC72, 1'b0);
    in_valid = 1'b1; bank = 2'd1; index = 4'd5;
    @(negedge Clk);
    in_valid = 1'b0;
    Reset_n = 1'b0;
    wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 4'd5; wr_data = 12'hFFF;
    @(negedge Clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fade_busy", 32'(fade_busy), 32'd0);
    chk("rst_fade_done", 32'(fade_done), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1; wr_en = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) m_mem[b][a] = 12'h000;
    m_lvl = 16;
    chk("rst_pending_lookups", 32'(sb.size()), 32'd0);
    chk("rst_no_done_pulse", 32'(done_cnt - d0), 32'd0);
    do_lookup(1, 5);
    do_lookup(0, 0);
    do_lookup(3, 15);
    drain();
    do_write(1, 5, 12'hE93);
    do_lookup(1, 5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
